// File: rtl/chain_dp_ctrl.sv
// Matrix-chain-multiplication DP sequencer: walks chain length, row and split,
// reads partial costs from the solution matrix and writes back min cost and split.
module chain_dp_ctrl #(
  parameter int MAXN = 30,
  parameter int PW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dim_we,
  input  logic [7:0]    dim_addr,
  input  logic [PW-1:0] dim_data,
  input  logic          start,
  input  logic [7:0]    n,
  output logic          rw,
  output logic [7:0]    iw,
  output logic [7:0]    jw,
  output logic [31:0]   min,
  output logic [31:0]   k,
  output logic [7:0]    ir,
  output logic [7:0]    jr,
  output logic [7:0]    kr,
  output logic          out,
  input  logic [31:0]   mik,
  input  logic [31:0]   mkj1,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   result
);

  localparam int AW = $clog2(MAXN + 1);
  localparam logic [7:0] MAXN8 = 8'(MAXN);

  typedef enum logic [2:0] {IDLE, INIT, SETUP, RD_A, RD_B, CALC, WRITE, DONE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] p [0:MAXN];
  logic [7:0]    nlen, nlen_nx, i, i_nx, j, j_nx, ks, ks_nx, len, len_nx, bk, bk_nx;
  logic [31:0]   best, best_nx, a, a_nx;
  logic          rw_nx, busy_nx, done_nx, err_nx;
  logic [7:0]    iw_nx, jw_nx, ir_nx, jr_nx, kr_nx;
  logic [31:0]   min_nx, k_nx, result_nx;
  logic [7:0]    k1, j1;
  logic [63:0]   prod, sum;
  logic [31:0]   cost;

  assign out = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int x = 0; x <= MAXN; x++) p[x] <= '0;
    end else if (dim_we && !busy && dim_addr <= MAXN8) begin
      p[dim_addr[AW-1:0]] <= dim_data;
    end
  end

  // Split cost: 64-bit unsigned sum, saturated to 32 bits.
  always_comb begin
    k1   = ks + 8'd1;
    j1   = j + 8'd1;
    prod = 64'(p[i[AW-1:0]]) * 64'(p[k1[AW-1:0]]) * 64'(p[j1[AW-1:0]]);
    sum  = 64'(a) + 64'(mkj1) + prod;
    cost = (sum[63:32] != 32'd0) ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      nlen   <= '0;
      i      <= '0;
      j      <= '0;
      ks     <= '0;
      len    <= '0;
      bk     <= '0;
      best   <= '0;
      a      <= '0;
      rw     <= 1'b0;
      iw     <= '0;
      jw     <= '0;
      min    <= '0;
      k      <= '0;
      ir     <= '0;
      jr     <= '0;
      kr     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      nlen   <= nlen_nx;
      i      <= i_nx;
      j      <= j_nx;
      ks     <= ks_nx;
      len    <= len_nx;
      bk     <= bk_nx;
      best   <= best_nx;
      a      <= a_nx;
      rw     <= rw_nx;
      iw     <= iw_nx;
      jw     <= jw_nx;
      min    <= min_nx;
      k      <= k_nx;
      ir     <= ir_nx;
      jr     <= jr_nx;
      kr     <= kr_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      err    <= err_nx;
      result <= result_nx;
    end
  end

  // Outputs are registered: each state's matrix action appears on the edge that leaves it.
  always_comb begin
    state_nx  = state;
    nlen_nx   = nlen;
    i_nx      = i;
    j_nx      = j;
    ks_nx     = ks;
    len_nx    = len;
    bk_nx     = bk;
    best_nx   = best;
    a_nx      = a;
    rw_nx     = 1'b0;
    iw_nx     = iw;
    jw_nx     = jw;
    min_nx    = min;
    k_nx      = k;
    ir_nx     = ir;
    jr_nx     = jr;
    kr_nx     = kr;
    busy_nx   = busy;
    done_nx   = 1'b0;
    err_nx    = err;
    result_nx = result;
    case (state)
      IDLE: begin
        if (start) begin
          nlen_nx = n;
          if (n == 8'd0 || n > MAXN8) begin
            err_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            err_nx   = 1'b0;
            busy_nx  = 1'b1;
            i_nx     = '0;
            state_nx = INIT;
          end
        end
      end
      INIT: begin
        rw_nx  = 1'b1;
        iw_nx  = i;
        jw_nx  = i;
        min_nx = '0;
        k_nx   = '0;
        if (i == nlen - 8'd1) begin
          if (nlen == 8'd1) begin
            result_nx = '0;
            state_nx  = DONE;
          end else begin
            len_nx   = 8'd2;
            i_nx     = '0;
            state_nx = SETUP;
          end
        end else begin
          i_nx = i + 8'd1;
        end
      end
      SETUP: begin
        j_nx     = i + len - 8'd1;
        best_nx  = 32'hFFFF_FFFF;
        bk_nx    = i;
        ks_nx    = i;
        state_nx = RD_A;
      end
      RD_A: begin
        ir_nx    = i;
        kr_nx    = ks;
        state_nx = RD_B;
      end
      RD_B: begin
        kr_nx    = k1;
        jr_nx    = j;
        a_nx     = mik;
        state_nx = CALC;
      end
      CALC: begin
        if (cost < best) begin
          best_nx = cost;
          bk_nx   = ks;
        end
        if (k1 < j) begin
          ks_nx    = k1;
          state_nx = RD_A;
        end else begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        rw_nx  = 1'b1;
        iw_nx  = i;
        jw_nx  = j;
        min_nx = best;
        k_nx   = {24'd0, bk};
        if (i == 8'd0 && j == nlen - 8'd1) begin
          result_nx = best;
          state_nx  = DONE;
        end else if (i + len < nlen) begin
          i_nx     = i + 8'd1;
          state_nx = SETUP;
        end else begin
          len_nx   = len + 8'd1;
          i_nx     = '0;
          state_nx = SETUP;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chain_dp_ctrl.sv
// Directed bench for chain_dp_ctrl with a behavioural solution matrix
// (address registered by the DUT, data returned combinationally one clock later).
module tb_chain_dp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dim_we;
  logic [7:0]  dim_addr;
  logic [15:0] dim_data;
  logic        start;
  logic [7:0]  n;
  logic        rw, dbg_out, busy, done, err;
  logic [7:0]  iw, jw, ir, jr, kr;
  logic [31:0] min, k, mik, mkj1, result;

  logic [31:0] mem [0:31][0:31];
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  chain_dp_ctrl #(.MAXN(30), .PW(16)) dut (
    .clk(clk), .rst(rst), .dim_we(dim_we), .dim_addr(dim_addr), .dim_data(dim_data),
    .start(start), .n(n), .rw(rw), .iw(iw), .jw(jw), .min(min), .k(k),
    .ir(ir), .jr(jr), .kr(kr), .out(dbg_out), .mik(mik), .mkj1(mkj1),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  assign mik  = mem[ir[4:0]][kr[4:0]];
  assign mkj1 = mem[kr[4:0]][jr[4:0]];

  always @(posedge clk) begin
    if (rw === 1'b1) begin
      mem[iw[4:0]][jw[4:0]] <= min;
      mem[jw[4:0]][iw[4:0]] <= k;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic write_dim(input logic [7:0] addr, input logic [15:0] data);
    dim_we = 1'b1; dim_addr = addr; dim_data = data;
    @(posedge clk); #1;
    dim_we = 1'b0;
  endtask

  // Starts a run and waits (bounded) for done; cyc = -1 if done never came.
  task automatic run(input logic [7:0] nn, input bit poke, output int cyc, output int wrs);
    int w0;
    w0 = wr_cnt;
    start = 1'b1; n = nn;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (poke && cyc == 2) begin
        start = 1'b1; n = 8'd5; dim_we = 1'b1; dim_addr = 8'd2; dim_data = 16'd999;
      end else begin
        start = 1'b0; dim_we = 1'b0;
      end
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    start = 1'b0; dim_we = 1'b0;
    if (done !== 1'b1) cyc = -1;
    wrs = wr_cnt - w0;
  endtask

  task automatic test_reset;
    rst = 1'b1; dim_we = 1'b0; dim_addr = '0; dim_data = '0; start = 1'b0; n = '0;
    #12;
    n_cmp++;
    if ({rw, busy, done, err, dbg_out} !== 5'b0) begin
      n_bad++; $display("[TB] FAIL reset_flags: got %b want 00000", {rw, busy, done, err, dbg_out});
    end
    n_cmp++;
    if (result !== 32'd0 || min !== 32'd0 || k !== 32'd0) begin
      n_bad++; $display("[TB] FAIL reset_data: got result=%0d min=%0d k=%0d want 0 0 0", result, min, k);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_two;
    int cyc, wrs;
    write_dim(8'd0, 16'd10); write_dim(8'd1, 16'd20); write_dim(8'd2, 16'd30);
    write_dim(8'd32, 16'd7);
    run(8'd2, 1'b1, cyc, wrs);
    n_cmp++;
    if (cyc !== 8) begin n_bad++; $display("[TB] FAIL two_cycles: got %0d want 8", cyc); end
    n_cmp++;
    if (wrs !== 3) begin n_bad++; $display("[TB] FAIL two_writes: got %0d want 3", wrs); end
    n_cmp++;
    if (result !== 32'd6000) begin n_bad++; $display("[TB] FAIL two_result: got %0d want 6000", result); end
    n_cmp++;
    if (mem[0][1] !== 32'd6000 || mem[1][0] !== 32'd0 || mem[1][1] !== 32'd0) begin
      n_bad++; $display("[TB] FAIL two_matrix: got m01=%0d m10=%0d m11=%0d want 6000 0 0", mem[0][1], mem[1][0], mem[1][1]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL two_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_three;
    int cyc, wrs;
    write_dim(8'd0, 16'd10); write_dim(8'd1, 16'd30); write_dim(8'd2, 16'd5); write_dim(8'd3, 16'd60);
    run(8'd3, 1'b0, cyc, wrs);
    n_cmp++;
    if (cyc !== 22) begin n_bad++; $display("[TB] FAIL three_cycles: got %0d want 22", cyc); end
    n_cmp++;
    if (wrs !== 6) begin n_bad++; $display("[TB] FAIL three_writes: got %0d want 6", wrs); end
    n_cmp++;
    if (mem[0][1] !== 32'd1500 || mem[1][2] !== 32'd9000) begin
      n_bad++; $display("[TB] FAIL three_pairs: got m01=%0d m12=%0d want 1500 9000", mem[0][1], mem[1][2]);
    end
    n_cmp++;
    if (mem[0][2] !== 32'd4500 || mem[2][0] !== 32'd1) begin
      n_bad++; $display("[TB] FAIL three_split: got m02=%0d s=%0d want 4500 1", mem[0][2], mem[2][0]);
    end
    n_cmp++;
    if (result !== 32'd4500) begin n_bad++; $display("[TB] FAIL three_result: got %0d want 4500", result); end
  endtask

  task automatic test_back_to_back;
    int cyc, wrs;
    run(8'd3, 1'b0, cyc, wrs);
    n_cmp++;
    if (cyc !== 22 || result !== 32'd4500) begin
      n_bad++; $display("[TB] FAIL b2b_run: got cyc=%0d result=%0d want 22 4500", cyc, result);
    end
  endtask

  task automatic test_tie;
    int cyc, wrs;
    for (int x = 0; x < 4; x++) write_dim(8'(x), 16'd1);
    run(8'd3, 1'b0, cyc, wrs);
    n_cmp++;
    if (mem[0][2] !== 32'd2 || mem[2][0] !== 32'd0) begin
      n_bad++; $display("[TB] FAIL tie_split: got m02=%0d s=%0d want 2 0", mem[0][2], mem[2][0]);
    end
    n_cmp++;
    if (result !== 32'd2) begin n_bad++; $display("[TB] FAIL tie_result: got %0d want 2", result); end
  endtask

  task automatic test_overflow;
    int cyc, wrs;
    for (int x = 0; x < 3; x++) write_dim(8'(x), 16'hFFFF);
    run(8'd2, 1'b0, cyc, wrs);
    n_cmp++;
    if (mem[0][1] !== 32'hFFFF_FFFF || mem[1][0] !== 32'd0) begin
      n_bad++; $display("[TB] FAIL ovf_matrix: got m01=%h s=%0d want ffffffff 0", mem[0][1], mem[1][0]);
    end
    n_cmp++;
    if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("[TB] FAIL ovf_result: got %h want ffffffff", result); end
  endtask

  task automatic test_illegal;
    logic [7:0] bad_n [2];
    int w0, cyc;
    bad_n[0] = 8'd0; bad_n[1] = 8'd31;
    for (int t = 0; t < 2; t++) begin
      w0 = wr_cnt;
      start = 1'b1; n = bad_n[t];
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++; $display("[TB] FAIL illegal_accept n=%0d: got err=%b busy=%b done=%b want 1 0 0", bad_n[t], err, busy, done);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b1 || err !== 1'b1) begin
        n_bad++; $display("[TB] FAIL illegal_done n=%0d: got done=%b err=%b want 1 1", bad_n[t], done, err);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (wr_cnt - w0 !== 0 || done !== 1'b0) begin
        n_bad++; $display("[TB] FAIL illegal_nowrite n=%0d: got writes=%0d done=%b want 0 0", bad_n[t], wr_cnt - w0, done);
      end
    end
    start = 1'b1; n = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("[TB] FAIL illegal_clear: got err=%b busy=%b want 0 1", err, busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (cyc !== 8 || result !== 32'hFFFF_FFFF) begin
      n_bad++; $display("[TB] FAIL illegal_rerun: got cyc=%0d result=%h want 8 ffffffff", cyc, result);
    end
  endtask

  task automatic test_midrun_reset;
    logic [15:0] pv [5];
    int w0, cyc, wrs;
    pv[0] = 16'd1; pv[1] = 16'd2; pv[2] = 16'd3; pv[3] = 16'd4; pv[4] = 16'd5;
    for (int x = 0; x < 5; x++) write_dim(8'(x), pv[x]);
    w0 = wr_cnt;
    start = 1'b1; n = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rw !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_bad++; $display("[TB] FAIL mid_reset: got busy=%b rw=%b done=%b result=%0d want 0 0 0 0", busy, rw, done, result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (wr_cnt - w0 !== 4) begin n_bad++; $display("[TB] FAIL mid_writes: got %0d want 4", wr_cnt - w0); end
    run(8'd2, 1'b0, cyc, wrs);
    n_cmp++;
    if (mem[0][1] !== 32'd0) begin n_bad++; $display("[TB] FAIL mid_dims_cleared: got %0d want 0", mem[0][1]); end
    for (int x = 0; x < 5; x++) write_dim(8'(x), pv[x]);
    run(8'd4, 1'b0, cyc, wrs);
    n_cmp++;
    if (cyc !== 47 || wrs !== 10) begin
      n_bad++; $display("[TB] FAIL mid_rerun_timing: got cyc=%0d writes=%0d want 47 10", cyc, wrs);
    end
    n_cmp++;
    if (result !== 32'd38 || mem[0][3] !== 32'd38 || mem[3][0] !== 32'd2) begin
      n_bad++; $display("[TB] FAIL mid_rerun_result: got result=%0d m03=%0d s=%0d want 38 38 2", result, mem[0][3], mem[3][0]);
    end
  endtask

  initial begin
    $display("[TB] chain_dp_ctrl directed tests");
    test_reset();
    test_two();
    test_three();
    test_back_to_back();
    test_tie();
    test_overflow();
    test_illegal();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
